// File: rtl/anota_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | anota_pkg                                                                |
// | Shared definitions for the anOTA SPI trim responder: register map        |
// | addresses, frame geometry and the frame FSM state encoding.              |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
package anota_pkg;

   localparam logic [3:0] ADDR_TRIM   = 4'd0;
   localparam logic [3:0] ADDR_CTRL   = 4'd1;
   localparam logic [3:0] ADDR_STATUS = 4'd2;
   localparam logic [3:0] ADDR_ID     = 4'd3;

   localparam int FRAME_BITS = 16;
   localparam int HDR_BITS   = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HDR  = 2'd1,
      DATA = 2'd2,
      DONE = 2'd3
   } anota_state_e;

endpackage : anota_pkg
`default_nettype wire

// File: rtl/anota_sync_bit.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | anota_sync_bit                                                           |
// | Multi-flop synchronizer for one asynchronous input bit.                  |
// | Ports: clk, rst_n (async assert, active-low), i_async (raw pin),         |
// |        o_sync (value after SYNC_STAGES flops).                           |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module anota_sync_bit #(
   parameter int   SYNC_STAGES = 2,
   parameter logic RST_VAL     = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_async,
   output logic o_sync
);

   logic [SYNC_STAGES-1:0] r_chain;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_chain <= {SYNC_STAGES{RST_VAL}};
      end else begin
         r_chain <= {r_chain[SYNC_STAGES-2:0], i_async};
      end
   end

   assign o_sync = r_chain[SYNC_STAGES-1];

endmodule : anota_sync_bit
`default_nettype wire

// File: rtl/anota_spi_trim_responder.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | anota_spi_trim_responder                                                 |
// | Oversampled SPI mode-0 responder holding the OTA TRIM/CTRL registers,    |
// | a comparator STATUS register and a fixed ID. 16-bit frames, MSB first:   |
// | {W, ADDR[3:0], rsvd[2:0], DATA[7:0]}.                                    |
// | Ports: clk, rst_n (async assert, active-low); sclk_i, cs_n_i, mosi_i,    |
// |        comp_i (async pins); miso_o; trim_o[7:0]; ctrl_o[7:0]; busy_o.   |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module anota_spi_trim_responder
   import anota_pkg::*;
#(
   parameter int         SYNC_STAGES = 2,
   parameter logic [7:0] ID_VALUE    = 8'hA5,
   parameter logic [7:0] TRIM_RST    = 8'h80,
   parameter logic [7:0] CTRL_RST    = 8'h00
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       sclk_i,
   input  logic       cs_n_i,
   input  logic       mosi_i,
   input  logic       comp_i,
   output logic       miso_o,
   output logic [7:0] trim_o,
   output logic [7:0] ctrl_o,
   output logic       busy_o
);

   localparam logic [4:0] c_HDR_LAST   = 5'(HDR_BITS - 1);
   localparam logic [4:0] c_FRAME_LAST = 5'(FRAME_BITS - 1);
   localparam int         c_SETTLE_W   = $clog2(SYNC_STAGES + 1);

   logic w_sclk_s, w_cs_n_s, w_mosi_s, w_comp_s;

   anota_sync_bit #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
      .clk(clk), .rst_n(rst_n), .i_async(sclk_i), .o_sync(w_sclk_s));
   anota_sync_bit #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs_n (
      .clk(clk), .rst_n(rst_n), .i_async(cs_n_i), .o_sync(w_cs_n_s));
   anota_sync_bit #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
      .clk(clk), .rst_n(rst_n), .i_async(mosi_i), .o_sync(w_mosi_s));
   anota_sync_bit #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_comp (
      .clk(clk), .rst_n(rst_n), .i_async(comp_i), .o_sync(w_comp_s));

   anota_state_e          r_state, w_state_nxt;
   logic                  r_sclk_d, r_cs_n_d;
   logic [c_SETTLE_W-1:0] r_settle_cnt;
   logic                  r_armed;
   logic [4:0]            r_bit_cnt;
   logic [6:0]            r_shift;
   logic                  r_wr;
   logic [3:0]            r_addr;
   logic [7:0]            r_rd_sh;
   logic                  r_miso;
   logic [7:0]            r_trim, r_ctrl;
   logic                  r_err;

   logic       w_sclk_rise, w_sclk_fall, w_cs_fall, w_cs_rise;
   logic [7:0] w_shift_byte, w_rd_data;
   logic       w_start, w_hdr_done, w_frame_done, w_abort, w_overrun;
   logic       w_err_clr;

   assign w_sclk_rise  = w_sclk_s & ~r_sclk_d;
   assign w_sclk_fall  = ~w_sclk_s & r_sclk_d;
   assign w_cs_fall    = ~w_cs_n_s & r_cs_n_d;
   assign w_cs_rise    = w_cs_n_s & ~r_cs_n_d;
   assign w_shift_byte = {r_shift, w_mosi_s};

   // Read source selected by the header byte completing this clk; STATUS is
   // captured here, so comp changes later in the frame do not alter the read.
   always_comb begin
      w_rd_data = 8'h00;
      case (w_shift_byte[6:3])
         ADDR_TRIM:   w_rd_data = r_trim;
         ADDR_CTRL:   w_rd_data = r_ctrl;
         ADDR_STATUS: w_rd_data = {6'b0, r_err, w_comp_s};
         ADDR_ID:     w_rd_data = ID_VALUE;
         default:     w_rd_data = 8'h00;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_start      = 1'b0;
      w_hdr_done   = 1'b0;
      w_frame_done = 1'b0;
      w_abort      = 1'b0;
      w_overrun    = 1'b0;
      case (r_state)
         IDLE: begin
            if (r_armed && w_cs_fall) begin
               w_start     = 1'b1;
               w_state_nxt = HDR;
            end
         end
         HDR: begin
            if (w_cs_rise) begin
               w_abort     = 1'b1;
               w_state_nxt = IDLE;
            end else if (w_sclk_rise && r_bit_cnt == c_HDR_LAST) begin
               w_hdr_done  = 1'b1;
               w_state_nxt = DATA;
            end
         end
         DATA: begin
            // A 16th rise coinciding with cs release still completes the frame.
            if (w_sclk_rise && r_bit_cnt == c_FRAME_LAST) begin
               w_frame_done = 1'b1;
               w_state_nxt  = w_cs_rise ? IDLE : DONE;
            end else if (w_cs_rise) begin
               w_abort     = 1'b1;
               w_state_nxt = IDLE;
            end
         end
         DONE: begin
            if (w_cs_rise)        w_state_nxt = IDLE;
            else if (w_sclk_rise) w_overrun   = 1'b1;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   assign w_err_clr = w_frame_done & ~r_wr & (r_addr == ADDR_STATUS);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sclk_d     <= 1'b0;
         r_cs_n_d     <= 1'b1;
         r_settle_cnt <= '0;
         r_armed      <= 1'b0;
         r_bit_cnt    <= 5'd0;
         r_shift      <= 7'd0;
         r_wr         <= 1'b0;
         r_addr       <= 4'd0;
         r_rd_sh      <= 8'h00;
         r_miso       <= 1'b0;
         r_trim       <= TRIM_RST;
         r_ctrl       <= CTRL_RST;
         r_err        <= 1'b0;
      end else begin
         r_sclk_d <= w_sclk_s;
         r_cs_n_d <= w_cs_n_s;

         // The cs_n chain comes out of reset reading "deselected"; a frame
         // already in flight at reset would look like a fresh falling edge.
         // Only arm once the chain carries real pin data showing cs_n high.
         if (r_settle_cnt != c_SETTLE_W'(SYNC_STAGES))
            r_settle_cnt <= r_settle_cnt + 1'b1;
         else if (w_cs_n_s)
            r_armed <= 1'b1;

         if (w_start) begin
            r_bit_cnt <= 5'd0;
            r_shift   <= 7'd0;
         end else if ((r_state == HDR || r_state == DATA) && w_sclk_rise) begin
            r_bit_cnt <= r_bit_cnt + 5'd1;
            r_shift   <= w_shift_byte[6:0];
         end

         if (w_hdr_done) begin
            r_wr    <= w_shift_byte[7];
            r_addr  <= w_shift_byte[6:3];
            r_rd_sh <= w_shift_byte[7] ? 8'h00 : w_rd_data;
         end else if (r_state == DATA && w_sclk_fall) begin
            r_rd_sh <= {r_rd_sh[6:0], 1'b0};
         end

         if (r_state == IDLE || r_state == HDR)
            r_miso <= 1'b0;
         else if (r_state == DATA && w_sclk_fall)
            r_miso <= r_rd_sh[7];

         if (w_frame_done && r_wr) begin
            if (r_addr == ADDR_TRIM) r_trim <= w_shift_byte;
            if (r_addr == ADDR_CTRL) r_ctrl <= w_shift_byte;
         end

         // A new error in the same clk as the read-clear wins.
         r_err <= (r_err & ~w_err_clr) | w_abort | w_overrun;
      end
   end

   assign miso_o = r_miso;
   assign trim_o = r_trim;
   assign ctrl_o = r_ctrl;
   assign busy_o = ~w_cs_n_s & (r_state != IDLE);

endmodule : anota_spi_trim_responder
`default_nettype wire

// File: tb/tb_anota_spi_trim_responder.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_anota_spi_trim_responder                                              |
// | Directed self-checking bench: SPI frames driven from clk negedges with   |
// | SCLK = clk/16; MISO sampled on negedges just before each SCLK rise.      |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module tb_anota_spi_trim_responder;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       sclk_i, cs_n_i, mosi_i, comp_i;
   logic       miso_o;
   logic [7:0] trim_o, ctrl_o;
   logic       busy_o;

   int         n_checks = 0;
   int         n_pass   = 0;
   logic [7:0] rd_byte;

   always #5 clk = ~clk;

   anota_spi_trim_responder #(
      .SYNC_STAGES(2), .ID_VALUE(8'hA5), .TRIM_RST(8'h80), .CTRL_RST(8'h00)
   ) u_dut (
      .clk(clk), .rst_n(rst_n), .sclk_i(sclk_i), .cs_n_i(cs_n_i),
      .mosi_i(mosi_i), .comp_i(comp_i), .miso_o(miso_o),
      .trim_o(trim_o), .ctrl_o(ctrl_o), .busy_o(busy_o)
   );

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", tag, got, exp);
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   // One SCLK period; MISO is sampled before the rise, so after a full frame
   // rd_byte holds the eight bits presented during the DATA phase.
   task automatic send_bit(input logic b);
      mosi_i = b;
      wait_clk(4);
      rd_byte = {rd_byte[6:0], miso_o};
      sclk_i = 1'b1;
      wait_clk(8);
      sclk_i = 1'b0;
      wait_clk(4);
   endtask

   task automatic frame_begin();
      rd_byte = 8'h00;
      cs_n_i  = 1'b0;
      wait_clk(8);
   endtask

   task automatic frame_end();
      wait_clk(4);
      cs_n_i = 1'b1;
      wait_clk(10);
   endtask

   task automatic frame(input logic [15:0] word, input int nbits);
      frame_begin();
      for (int i = 0; i < nbits; i++) send_bit((i < 16) ? word[15 - i] : 1'b0);
      frame_end();
   endtask

   initial begin
      rst_n  = 1'b0;
      sclk_i = 1'b0;
      cs_n_i = 1'b1;
      mosi_i = 1'b0;
      comp_i = 1'b0;
      wait_clk(5);
      check("rst_miso", miso_o, 0);
      check("rst_trim", trim_o, 16'h80);
      check("rst_ctrl", ctrl_o, 16'h00);
      check("rst_busy", busy_o, 0);
      rst_n = 1'b1;
      wait_clk(10);

      // Read ID; busy observed mid-frame
      frame_begin();
      for (int i = 0; i < 16; i++) begin
         send_bit(i == 3 || i == 4);
         if (i == 2) check("busy_mid", busy_o, 1);
      end
      frame_end();
      check("id_read", rd_byte, 16'hA5);
      check("id_trim", trim_o, 16'h80);
      check("id_ctrl", ctrl_o, 16'h00);
      check("busy_idle", busy_o, 0);

      // Write 0x3C to TRIM with commit timing on the 16th rise
      begin
         logic [15:0] w;
         w = 16'h803C;
         frame_begin();
         for (int i = 0; i < 15; i++) send_bit(w[15 - i]);
         mosi_i = w[0];
         wait_clk(4);
         sclk_i = 1'b1;
         @(posedge clk); @(posedge clk); #1;
         check("trim_before_commit", trim_o, 16'h80);
         @(posedge clk); #1;
         check("trim_at_commit", trim_o, 16'h3C);
         wait_clk(8);
         sclk_i = 1'b0;
         wait_clk(4);
         frame_end();
      end
      frame(16'h0000, 16);
      check("trim_readback", rd_byte, 16'h3C);

      // Aborted write to CTRL after 10 bits
      frame(16'h88FF, 10);
      check("abort_ctrl", ctrl_o, 16'h00);
      frame(16'h1000, 16);
      check("status_err_set", rd_byte, 16'h02);
      frame(16'h1000, 16);
      check("status_err_clr", rd_byte, 16'h00);

      // Comparator status and snapshot behaviour
      comp_i = 1'b1;
      wait_clk(10);
      frame(16'h1000, 16);
      check("status_comp1", rd_byte, 16'h01);
      frame_begin();
      for (int i = 0; i < 8; i++) send_bit(i == 3);
      comp_i = 1'b0;
      for (int i = 0; i < 8; i++) send_bit(1'b0);
      frame_end();
      check("status_snapshot", rd_byte, 16'h01);
      frame(16'h1000, 16);
      check("status_comp0", rd_byte, 16'h00);

      // 17 clocks on a write: one commit, error flagged
      frame(16'h8055, 17);
      check("overrun_trim", trim_o, 16'h55);
      frame(16'h1000, 16);
      check("overrun_err", rd_byte, 16'h02);

      // Reset in the middle of a write to CTRL
      begin
         logic [15:0] w;
         w = 16'h8877;
         frame_begin();
         for (int i = 0; i < 6; i++) send_bit(w[15 - i]);
         rst_n = 1'b0;
         wait_clk(3);
         check("midrst_trim", trim_o, 16'h80);
         check("midrst_ctrl", ctrl_o, 16'h00);
         check("midrst_miso", miso_o, 0);
         check("midrst_busy", busy_o, 0);
         rst_n = 1'b1;
         for (int i = 6; i < 16; i++) send_bit(w[15 - i]);
         frame_end();
      end
      check("after_rst_ctrl", ctrl_o, 16'h00);
      frame(16'h1000, 16);
      check("after_rst_status", rd_byte, 16'h00);
      frame(16'h8812, 16);
      check("ctrl_write", ctrl_o, 16'h12);
      check("ctrl_write_trim", trim_o, 16'h80);
      frame(16'h0800, 16);
      check("ctrl_readback", rd_byte, 16'h12);
      frame(16'h2800, 16);
      check("unmapped_read", rd_byte, 16'h00);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule : tb_anota_spi_trim_responder
`default_nettype wire

// File: doc/anota_spi_trim_responder.md
Name: anota_spi_trim_responder

Overview:
- SPI-mode-0 responder inside the anOTA tile; the bench or MCU is the initiator, driving SCLK/CS_N/MOSI on ui_in and reading MISO on uo_out.
- Holds the OTA trim and control registers and returns a synchronized comparator status plus a fixed ID.
- Oversampled design: all SPI pins are synchronized into clk; no logic is clocked by SCLK.

Parameters:
- SYNC_STAGES, 2, flops per input synchronizer (>=2).
- ID_VALUE, 8'hA5, read-only ID register content.
- TRIM_RST, 8'h80, reset value of TRIM register (mid-scale).
- CTRL_RST, 8'h00, reset value of CTRL register.

Ports:
- clk  in  1  system clock; must run at least 8x SCLK.
- rst_n  in  1  reset, asynchronous assert, active-low.
- sclk_i  in  1  SPI clock, async to clk.
- cs_n_i  in  1  SPI chip select, active-low, async.
- mosi_i  in  1  SPI data in, async.
- comp_i  in  1  OTA comparator-mode output, async.
- miso_o  out  1  SPI data out.
- trim_o  out  8  TRIM register to the OTA bias DAC.
- ctrl_o  out  8  CTRL register (enable, mode bits).
- busy_o  out  1  high while a frame is in progress (cs low, synchronized).

Behaviour:
- Interface: one clock; reset is asynchronous and active-low; ports named clk and rst_n.
- Reset values: miso_o=0, trim_o=TRIM_RST, ctrl_o=CTRL_RST, busy_o=0, sticky frame error=0, FSM=IDLE.
- Sync and edge detection: sclk, cs_n, mosi and comp each pass through SYNC_STAGES flops.
- sclk rise/fall detection uses the synchronized value and one extra delayed flop.
- Frame: 16 bits, MSB first, sampled on sclk rise.
- Frame bit 15 is W (1=write, 0=read); bits 14:11 are ADDR; bits 10:8 are reserved (ignored); bits 7:0 are DATA.
- Register map:
  - 0 TRIM RW.
  - 1 CTRL RW.
  - 2 STATUS RO: bit0 = synchronized comp, bit1 = sticky frame error, others 0.
  - 3 ID RO = ID_VALUE.
  - 4-15 read 0x00; writes are ignored.
- FSM states:
  - IDLE: cs_n falling edge (synchronized) -> HDR; clear bit counter and shift register.
  - HDR: shift 8 bits; on the 8th rise latch W/ADDR -> DATA. For a read, load the read-data shifter at that point (STATUS is snapshotted).
  - DATA: shift 8 bits; on the 16th rise -> DONE.
  - DONE: for a write, commit DATA to TRIM or CTRL one clk after the 16th rise. Further sclk rises while cs is low set the frame error; no second commit. cs_n rise -> IDLE.
  - Any state, cs_n rise before the 16th rise: abort -> IDLE. No register changes; set the frame error.
- MISO: drives 0 in HDR. On each sclk fall in DATA, drive the next read bit, MSB first. The first bit (data[7]) is driven on the fall following the 8th rise.
  - Latency from pin fall to miso_o change is SYNC_STAGES+1 clk.
  - miso_o returns to 0 in IDLE.
  - On write frames miso_o stays 0.
- Simultaneous events: if the 16th rise and cs_n rise are detected in the same clk, the frame is complete and the write commits; no error.
- Sticky error: cleared one clk after a completed read of STATUS (addr 2). The read itself returns the pre-clear value. If a new error occurs in the same clk as the clear, set wins.
- busy_o = synchronized cs_n low and FSM != IDLE.
- Reset mid-frame: all state returns to reset values immediately. The remainder of the frame is ignored until the next cs_n falling edge.

Decomposition:
- Shared package anota_pkg:
  - Address localparams ADDR_TRIM=0, ADDR_CTRL=1, ADDR_STATUS=2, ADDR_ID=3.
  - FRAME_BITS=16.
  - FSM state enum {IDLE, HDR, DATA, DONE}.
- One sub-module anota_sync_bit: parameterized SYNC_STAGES flop chain with async active-low reset to a reset-value parameter. Instantiated four times; cs_n resets to 1, the others to 0.

Test Plan:
- Reset then read addr 3 -> MISO shifts 0xA5; trim_o=0x80 and ctrl_o=0x00 throughout.
- Write 0x3C to addr 0, then read addr 0 -> trim_o=0x3C exactly one clk after the 16th sync rise; readback 0x3C.
- Raise cs_n after 10 bits of a write 0xFF to addr 1 -> ctrl_o unchanged at 0x00. A following STATUS read returns bit1=1; a second STATUS read returns bit1=0.
- Hold comp_i=1 and read STATUS -> 0x01. Toggle comp_i during the DATA phase -> the returned value is unchanged (snapshot).
- Send 17 sclk pulses on a write 0x55 to addr 0 -> trim_o=0x55 committed once; sticky error set.
- Assert rst_n low mid-write -> outputs at reset values. The next full write 0x12 to addr 1 gives ctrl_o=0x12.
